// File: rtl/sync_pulse_tx.sv
// sync_pulse_tx: turns single-cycle bclk events into four-phase req/ack handshakes toward another clock domain, queuing events that arrive while a handshake is in flight.
// Ports: bclk, rst (async, active-high), pulse_in, ack_in (async level) -> req_out, busy, pending[CNT_W], overflow, done_pulse, timeout_err.
// Define SYNC_PULSE_TX_TIMEOUT_EN to abort a REQ phase that sees no ack for TIMEOUT_CYC cycles.
module sync_pulse_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             bclk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             done_pulse,
  output logic             timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, ACK_HI} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic req_q, req_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic ack_s, start, inc, full, tmo_hit, aborted;
  assign ack_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
    start = state_q == IDLE && (pulse_in || pend_q != '0);
    // a start takes pulse_in first, so only an unconsumed pulse adds to the backlog
    inc = pulse_in && !start;
    full = &pend_q;
    pend_d = inc ? (full ? pend_q : pend_q + CNT_W'(1))
           : (start && !pulse_in) ? pend_q - CNT_W'(1) : pend_q;
    ovf_d = ovf_q || (inc && full);
    state_d = state_q == IDLE ? (start ? REQ : IDLE)
            : state_q == REQ ? ((ack_s || tmo_hit) ? ACK_HI : REQ)
            : (ack_s ? ACK_HI : IDLE);
    req_d = state_d == REQ;
    busy_d = state_d != IDLE;
    done_d = state_q == ACK_HI && !ack_s && !aborted;
  end
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      pend_q <= '0;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      pend_q <= pend_d;
      req_q <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef SYNC_PULSE_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic abort_q, abort_d, err_q, err_d;
  always_comb begin
    // tmo_d is the number of REQ cycles including this one
    tmo_d = state_q == REQ ? tmo_q + TO_W'(1) : '0;
    tmo_hit = state_q == REQ && !ack_s && tmo_d == TO_W'(TIMEOUT_CYC);
    // an aborted handshake still drains through ACK_HI but must not report completion
    abort_d = tmo_hit || (abort_q && state_q == ACK_HI && ack_s);
    err_d = err_q || tmo_hit;
  end
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      abort_q <= abort_d;
      err_q <= err_d;
    end
  end
  assign aborted = abort_q;
  assign timeout_err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign aborted = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign req_out = req_q;
  assign busy = busy_q;
  assign pending = pend_q;
  assign overflow = ovf_q;
  assign done_pulse = done_q;
endmodule
